// File: rtl/answer_judge.sv
// answer_judge: player-side judge that fetches factorization questions, checks factor pairs and tracks HP/score.
module answer_judge #(
  parameter int TIME_LIMIT  = 1000,
  parameter int RESULT_HOLD = 4,
  parameter int HP_INIT     = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        QUE_OK,
  input  logic [23:0] QUESTION,
  input  logic        ENTER,
  input  logic [3:0]  P_IN,
  input  logic [3:0]  Q_IN,
  output logic        QUE,
  output logic [1:0]  JUDG,
  output logic        WRONG,
  output logic [1:0]  HP,
  output logic [7:0]  SCORE,
  output logic        BUSY
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_Q, ANSWER, CHECK, RESULT, OVER} state_t;
  localparam int TW = $clog2(TIME_LIMIT + 1);
  localparam int HW = $clog2(RESULT_HOLD + 1);
  state_t state, nxt;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold;
  logic signed [7:0] b, c, pe, qe, sum, prod;
  logic [3:0] p, q;
  logic ok, good, timeout, hold_done, enter_res, unused_rsvd;
  assign unused_rsvd = ^QUESTION[7:0];
  assign pe = {{4{p[3]}}, p};
  assign qe = {{4{q[3]}}, q};
  assign sum = pe + qe;
  assign prod = pe * qe;
  assign ok = (sum == b) && (prod == c);
  assign good = (state == CHECK) && ok;
  assign timeout = timer == TW'(TIME_LIMIT - 1);
  assign hold_done = hold == HW'(RESULT_HOLD - 1);
  assign enter_res = (nxt == RESULT) && (state != RESULT);
  assign QUE = state == REQ;
  assign BUSY = (state != IDLE) && (state != OVER);
  always_comb begin
    nxt = state;
    case (state)
      IDLE, OVER: nxt = START ? REQ : state;
      REQ:        nxt = WAIT_Q;
      WAIT_Q:     nxt = QUE_OK ? ANSWER : WAIT_Q;
      ANSWER:     nxt = ENTER ? CHECK : timeout ? RESULT : ANSWER;
      CHECK:      nxt = RESULT;
      RESULT:     nxt = !hold_done ? RESULT : (HP == 2'd0) ? OVER : REQ;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      timer <= '0;
      hold  <= '0;
      b     <= '0;
      c     <= '0;
      p     <= '0;
      q     <= '0;
      JUDG  <= 2'b00;
      WRONG <= 1'b0;
      HP    <= 2'(HP_INIT);
      SCORE <= '0;
    end else begin
      state <= nxt;
      WRONG <= enter_res && !good;
      if ((state == IDLE || state == OVER) && START) begin
        HP    <= 2'(HP_INIT);
        SCORE <= '0;
        JUDG  <= 2'b00;
      end
      if (state == WAIT_Q && QUE_OK) begin
        {b, c} <= QUESTION[23:8];
        timer  <= '0;
      end
      if (state == ANSWER) timer <= timer + 1'b1;
      if (state == ANSWER && ENTER) begin
        p <= P_IN;
        q <= Q_IN;
      end
      // HP already reflects this verdict by the time RESULT decides OVER vs REQ
      if (enter_res) begin
        JUDG <= good ? 2'b01 : 2'b10;
        hold <= '0;
        if (good) SCORE <= SCORE + 8'(SCORE != 8'hFF);
        else HP <= HP - 2'(HP != 2'd0);
      end
      if (state == RESULT) begin
        hold <= hold + 1'b1;
        if (hold_done) JUDG <= (HP == 2'd0) ? 2'b11 : 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_answer_judge.sv
// tb_answer_judge: directed stimulus with a verdict scoreboard checked by an independent monitor.
module tb_answer_judge;
  logic CLK = 0, RST, START, QUE_OK, ENTER;
  logic [23:0] QUESTION;
  logic [3:0] P_IN, Q_IN;
  logic QUE, WRONG, BUSY;
  logic [1:0] JUDG, HP;
  logic [7:0] SCORE;
  answer_judge dut (
    .CLK(CLK), .RST(RST), .START(START), .QUE_OK(QUE_OK), .QUESTION(QUESTION),
    .ENTER(ENTER), .P_IN(P_IN), .Q_IN(Q_IN), .QUE(QUE), .JUDG(JUDG),
    .WRONG(WRONG), .HP(HP), .SCORE(SCORE), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc++;
  typedef struct {
    logic [1:0] judg;
    logic       wrong;
    logic [1:0] hp;
    logic [7:0] sc;
    int         at;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0, hp_m = 3, sc_m = 0;
  bit mon_en = 0;
  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  logic [1:0] prev = 2'b00;
  int hold = 0;
  always @(negedge CLK) begin : mon
    exp_t e;
    if (mon_en) begin
      if (JUDG != prev && JUDG != 2'b00) begin
        if (sb.size() == 0) check("unexpected_judg", int'(JUDG), 0);
        else begin
          e = sb.pop_front();
          check("judg", int'(JUDG), int'(e.judg));
          check("wrong", int'(WRONG), int'(e.wrong));
          check("hp", int'(HP), int'(e.hp));
          check("score", int'(SCORE), int'(e.sc));
          check("verdict_cycle", cyc, e.at);
        end
      end else if (WRONG) check("wrong_extra", int'(WRONG), 0);
      if (JUDG == 2'b01 || JUDG == 2'b10) hold++;
      else if (hold != 0) begin
        check("judg_hold", hold, 4);
        hold = 0;
      end
      prev = JUDG;
    end
  end
  task automatic start_game;
    START = 1;
    tick;
    START = 0;
    check("que_after_start", int'(QUE), 1);
    check("hp_reload", int'(HP), 3);
    check("score_clear", int'(SCORE), 0);
    check("busy_on", int'(BUSY), 1);
    hp_m = 3;
    sc_m = 0;
  endtask
  task automatic ask(input int b, input int c, output int a);
    tick;
    check("que_one_cycle", int'(QUE), 0);
    tick;
    QUESTION = {8'(b), 8'(c), 8'h5A};
    QUE_OK = 1;
    tick;
    QUE_OK = 0;
    QUESTION = '0;
    a = cyc;
  endtask
  task automatic verdict(input bit ok, input int e);
    exp_t x;
    if (ok) sc_m = (sc_m == 255) ? 255 : sc_m + 1;
    else hp_m = (hp_m == 0) ? 0 : hp_m - 1;
    x.judg = ok ? 2'b01 : 2'b10;
    x.wrong = !ok;
    x.hp = 2'(hp_m);
    x.sc = 8'(sc_m);
    x.at = e;
    sb.push_back(x);
    if (hp_m == 0) begin
      x.judg = 2'b11;
      x.wrong = 0;
      x.at = e + 4;
      sb.push_back(x);
    end
    for (int n = 0; n < 2000 && !((hp_m == 0) ? (JUDG == 2'b11) : QUE); n++) tick;
    check((hp_m == 0) ? "over_cycle" : "next_que_cycle", cyc, e + 4);
  endtask
  task automatic answer(input int p, input int q, input bit ok);
    int d;
    P_IN = 4'(p);
    Q_IN = 4'(q);
    ENTER = 1;
    d = cyc;
    tick;
    ENTER = 0;
    verdict(ok, d + 2);
  endtask
  task automatic qa(input int b, input int c, input int p, input int q, input bit ok);
    int a;
    ask(b, c, a);
    answer(p, q, ok);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int a, bad;
    RST = 1; START = 0; QUE_OK = 0; ENTER = 0; QUESTION = '0; P_IN = '0; Q_IN = '0;
    repeat (3) tick;
    RST = 0;
    check("rst_que", int'(QUE), 0);
    check("rst_judg", int'(JUDG), 0);
    check("rst_wrong", int'(WRONG), 0);
    check("rst_hp", int'(HP), 3);
    check("rst_score", int'(SCORE), 0);
    check("rst_busy", int'(BUSY), 0);
    mon_en = 1;
    start_game;
    qa(5, 6, 2, 3, 1);
    qa(-1, -6, -3, 2, 1);
    qa(-1, -6, 2, -3, 1);
    qa(5, 6, 1, 4, 0);
    qa(-16, 64, -8, -8, 1);
    qa(-1, -56, 7, -8, 1);
    ask(5, 6, a);
    verdict(0, a + 1000);
    ask(3, 2, a);
    while (cyc < a + 999) tick;
    answer(1, 2, 1);
    qa(0, 0, 1, 0, 0);
    check("over_busy", int'(BUSY), 0);
    check("over_judg", int'(JUDG), 3);
    check("over_hp", int'(HP), 0);
    bad = 0;
    repeat (10) begin
      tick;
      bad += int'(QUE);
    end
    check("que_in_over", bad, 0);
    check("over_score_held", int'(SCORE), sc_m);
    start_game;
    qa(5, 6, 1, 4, 0);
    qa(0, 0, 1, -1, 0);
    qa(0, 0, 3, 3, 0);
    start_game;
    qa(5, 6, 2, 3, 1);
    ask(5, 6, a);
    repeat (5) tick;
    RST = 1;
    tick;
    RST = 0;
    check("midrst_busy", int'(BUSY), 0);
    check("midrst_que", int'(QUE), 0);
    check("midrst_judg", int'(JUDG), 0);
    check("midrst_hp", int'(HP), 3);
    check("midrst_score", int'(SCORE), 0);
    QUESTION = {8'd5, 8'd6, 8'h00};
    QUE_OK = 1;
    ENTER = 1;
    P_IN = 4'd2;
    Q_IN = 4'd3;
    bad = 0;
    repeat (5) begin
      tick;
      bad += int'(BUSY) + int'(QUE) + int'(JUDG != 2'b00);
    end
    QUE_OK = 0;
    ENTER = 0;
    check("stray_inputs_ignored", bad, 0);
    start_game;
    qa(5, 6, 2, 3, 1);
    for (int n = 0; n < 50 && sb.size() != 0; n++) tick;
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
